// File: rtl/seq_and_reduce_sched.sv
// AND-reduces a WIDTH-bit vector by time-sharing one CHUNK-input reducer.
// Ports: clk, rst, input_bits/in_valid/in_ready, out/out_valid/out_ready, run_cycles.
module seq_and_reduce_sched #(
  parameter int WIDTH      = 256,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_bits,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      run_cycles
);

  function automatic int log_chunk(int w, int c);
    int l;
    int p;
    l = 0;
    p = 1;
    if (c < 2) return 0;
    while (p < w) begin
      p = p * c;
      l++;
    end
    return l;
  endfunction

  localparam int LEVELS = log_chunk(WIDTH, CHUNK);
  localparam int NCH    = WIDTH / CHUNK;
  localparam int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;

  if (CHUNK < 2 || LEVELS < 1 || CHUNK ** LEVELS != WIDTH) begin : g_bad_params
    $error("WIDTH must equal CHUNK**k with k>=1 and CHUNK>=2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] data_q;
  logic [IDX_W-1:0] idx;
  // Index of the last chunk in the current level; reaching zero
  // means the current level is the root.
  logic [IDX_W-1:0] last_idx;
  logic             r;
  logic             last_chunk;
  logic             finish;

  assign r          = &data_q[int'(idx) * CHUNK +: CHUNK];
  assign last_chunk = (idx == last_idx);
  assign finish     = (last_chunk && last_idx == '0) ||
                      (EARLY_EXIT != 0 && !r);

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (finish) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      idx        <= '0;
      last_idx   <= '0;
      out        <= 1'b0;
      run_cycles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q     <= input_bits;
            idx        <= '0;
            last_idx   <= IDX_W'(NCH - 1);
            run_cycles <= '0;
          end
        end
        RUN: begin
          // idx <= idx*CHUNK, so this only overwrites bits already consumed.
          data_q[idx] <= r;
          if (run_cycles != '1) run_cycles <= run_cycles + 16'd1;
          if (finish) begin
            out <= r;
          end else if (last_chunk) begin
            idx      <= '0;
            last_idx <= IDX_W'((int'(last_idx) + 1) / CHUNK - 1);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_and_reduce_sched.sv
// Bench for seq_and_reduce_sched: three configurations vs a tree model.
// Ports of each DUT are driven from this module.
module tb_seq_and_reduce_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [255:0] bits;
  logic         in_valid, out_ready;
  logic         rdy_a, out_a, ov_a;
  logic [15:0]  rc_a;
  logic         rdy_e, out_e, ov_e;
  logic [15:0]  rc_e;
  logic [7:0]   bits_s;
  logic         iv_s, ordy_s, rdy_s, out_s, ov_s;
  logic [15:0]  rc_s;

  int checks = 0;
  int failures = 0;

  seq_and_reduce_sched #(.WIDTH(256), .CHUNK(4), .EARLY_EXIT(0)) dut_a (
    .clk(clk), .rst(rst), .input_bits(bits), .in_valid(in_valid),
    .in_ready(rdy_a), .out(out_a), .out_valid(ov_a),
    .out_ready(out_ready), .run_cycles(rc_a));

  seq_and_reduce_sched #(.WIDTH(256), .CHUNK(4), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst(rst), .input_bits(bits), .in_valid(in_valid),
    .in_ready(rdy_e), .out(out_e), .out_valid(ov_e),
    .out_ready(out_ready), .run_cycles(rc_e));

  seq_and_reduce_sched #(.WIDTH(8), .CHUNK(2), .EARLY_EXIT(0)) dut_s (
    .clk(clk), .rst(rst), .input_bits(bits_s), .in_valid(iv_s),
    .in_ready(rdy_s), .out(out_s), .out_valid(ov_s),
    .out_ready(ordy_s), .run_cycles(rc_s));

  // Reduction tree evaluated level by level; counts chunk evaluations.
  function automatic void model(input logic [255:0] v, input int w,
                                input int c, input bit ee,
                                output bit o, output int cyc);
    bit cur[$];
    bit nxt[$];
    bit r;
    cyc = 0;
    o = 1'b1;
    for (int i = 0; i < w; i++) cur.push_back(v[i]);
    for (int lv = 0; lv < 16 && cur.size() > 1; lv++) begin
      nxt.delete();
      for (int j = 0; j < cur.size() / c; j++) begin
        r = 1'b1;
        for (int b = 0; b < c; b++) r &= cur[j*c+b];
        cyc++;
        if (ee && !r) begin
          o = 1'b0;
          return;
        end
        nxt.push_back(r);
      end
      cur = nxt;
    end
    o = cur[0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; bits = '0;
    iv_s = 1'b0; ordy_s = 1'b0; bits_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rdy_a, ov_a, out_a, rc_a} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_a got rdy=%b ov=%b out=%b rc=%0d exp 1 0 0 0",
               rdy_a, ov_a, out_a, rc_a);
    end
    checks++;
    if ({rdy_e, ov_e, rc_e, rdy_s, ov_s, rc_s} !==
        {1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL reset_es got rdy_e=%b ov_e=%b rc_e=%0d rdy_s=%b ov_s=%b rc_s=%0d",
               rdy_e, ov_e, rc_e, rdy_s, ov_s, rc_s);
    end
  endtask

  // One vector into both 256-bit DUTs with out_ready held high.
  task automatic run_pair(input logic [255:0] v, input string name);
    bit   oa_m, oe_m;
    int   ca_m, ce_m;
    int   ka, ke, k;
    logic oa, oe;
    logic [15:0] ra, re;
    model(v, 256, 4, 1'b0, oa_m, ca_m);
    model(v, 256, 4, 1'b1, oe_m, ce_m);
    ka = -1; ke = -1; oa = 1'bx; oe = 1'bx; ra = 'x; re = 'x;
    @(negedge clk);
    checks++;
    if (rdy_a !== 1'b1 || rdy_e !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_ready got %b%b exp 11", name, rdy_a, rdy_e);
    end
    in_valid = 1'b1; bits = v; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; bits = rnd256();
    for (k = 0; k < 200 && (ka < 0 || ke < 0); ) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (ov_a && ka < 0) begin ka = k; oa = out_a; ra = rc_a; end
      if (ov_e && ke < 0) begin ke = k; oe = out_e; re = rc_e; end
    end
    checks++;
    if (ka != ca_m || oa !== oa_m || ra !== 16'(ca_m)) begin
      failures++;
      $display("FAIL %s ee0 got lat=%0d out=%b rc=%0d exp lat=%0d out=%b rc=%0d",
               name, ka, oa, ra, ca_m, oa_m, ca_m);
    end
    checks++;
    if (ke != ce_m || oe !== oe_m || re !== 16'(ce_m)) begin
      failures++;
      $display("FAIL %s ee1 got lat=%0d out=%b rc=%0d exp lat=%0d out=%b rc=%0d",
               name, ke, oe, re, ce_m, oe_m, ce_m);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL %s after_handshake got ov=%b rdy=%b exp 0 1", name, ov_a, rdy_a);
    end
  endtask

  task automatic test_patterns();
    logic [255:0] v;
    run_pair({256{1'b1}}, "all_ones");
    v = {256{1'b1}}; v[255] = 1'b0;
    run_pair(v, "bit255_clr");
    v = {256{1'b1}}; v[0] = 1'b0;
    run_pair(v, "bit0_clr");
    for (int i = 0; i < 4; i++) begin
      v = {256{1'b1}};
      v[$urandom_range(255)] = 1'b0;
      run_pair(v, "rand_one_zero");
    end
    run_pair(rnd256(), "rand_full");
  endtask

  task automatic test_stall();
    int k;
    @(negedge clk);
    in_valid = 1'b1; bits = {256{1'b1}}; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bits = rnd256();
    k = 0;
    while (!ov_a && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    checks++;
    if (k != 85) begin
      failures++;
      $display("FAIL stall_latency got %0d exp 85", k);
    end
    for (int c = 0; c < 10; c++) begin
      bits = rnd256();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ov_a, out_a, rc_a, rdy_a} !== {1'b1, 1'b1, 16'd85, 1'b0}) begin
        failures++;
        $display("FAIL stall_hold got ov=%b out=%b rc=%0d rdy=%b exp 1 1 85 0",
                 ov_a, out_a, rc_a, rdy_a);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov_a, rdy_a, rc_a} !== {1'b0, 1'b1, 16'd85}) begin
      failures++;
      $display("FAIL stall_release got ov=%b rdy=%b rc=%0d exp 0 1 85",
               ov_a, rdy_a, rc_a);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; bits = {256{1'b1}}; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rc_a !== 16'd40 || ov_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_run_count got rc=%0d ov=%b exp 40 0", rc_a, ov_a);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({rdy_a, ov_a, rc_a} !== {1'b1, 1'b0, 16'd0}) begin
      failures++;
      $display("FAIL abort got rdy=%b ov=%b rc=%0d exp 1 0 0", rdy_a, ov_a, rc_a);
    end
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_result got ov=%b rdy=%b exp 0 1", ov_a, rdy_a);
    end
    run_pair({256{1'b1}}, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [7:0] vs[$];
    bit   om;
    int   cm, k;
    vs = '{8'hFF, 8'hEF};
    for (int i = 0; i < 4; i++) vs.push_back(8'($urandom));
    @(negedge clk);
    iv_s = 1'b1; ordy_s = 1'b1;
    foreach (vs[i]) begin
      model(256'(vs[i]), 8, 2, 1'b0, om, cm);
      checks++;
      if (rdy_s !== 1'b1) begin
        failures++;
        $display("FAIL b2b_idle[%0d] got rdy=%b exp 1", i, rdy_s);
      end
      bits_s = vs[i];
      @(posedge clk);
      @(negedge clk);
      bits_s = 8'($urandom);
      checks++;
      if (rdy_s !== 1'b0) begin
        failures++;
        $display("FAIL b2b_accept[%0d] got rdy=%b exp 0", i, rdy_s);
      end
      k = 0;
      while (!ov_s && k < 50) begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
      checks++;
      if (k != cm || out_s !== om || rc_s !== 16'(cm)) begin
        failures++;
        $display("FAIL b2b_result[%0d] v=%h got lat=%0d out=%b rc=%0d exp lat=%0d out=%b rc=%0d",
                 i, vs[i], k, out_s, rc_s, cm, om, cm);
      end
      @(posedge clk);
      @(negedge clk);
    end
    iv_s = 1'b0;
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
